// File: rtl/ps2_frame_receiver_if.sv
// Signal bundle between the PS/2 edge front end, the frame receiver and the scancode decoder.
// The master drives enable/edge/data and observes the receiver outputs; the slave is the receiver.
interface ps2_frame_receiver_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx_enable;
   logic                 ps2_clk_posedge;
   logic                 ps2_data;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_error;
   logic [1:0]           rx_error_code;
   logic                 rx_busy;

   modport master (
      output rx_enable, ps2_clk_posedge, ps2_data,
      input  rx_data, rx_valid, rx_error, rx_error_code, rx_busy
   );

   modport slave (
      input  rx_enable, ps2_clk_posedge, ps2_data,
      output rx_data, rx_valid, rx_error, rx_error_code, rx_busy
   );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start, LSB-first data, optional odd parity, stop, with inactivity timeout.
// Result strobes one cycle after the stop edge (or timeout); no backpressure, strobes must be consumed when seen.
module ps2_frame_receiver #(
   parameter int DATA_BITS      = 8,
   parameter int PARITY_EN      = 1,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic                 clk,
   input  logic                 rst,
   ps2_frame_receiver_if.slave  bus
);
   localparam int CW = $clog2(DATA_BITS + 1);
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic [TW-1:0]        to_q, to_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic [1:0]           code_q, code_d;

   logic edge_s;
   logic din_s;
   assign edge_s = bus.ps2_clk_posedge;
   assign din_s  = bus.ps2_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         to_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         to_q    <= to_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      to_d    = to_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;

      if (state_q == IDLE || edge_s) begin
         to_d = '0;
      end else begin
         to_d = to_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (edge_s && !din_s && bus.rx_enable) begin
               state_d = DATA;
               cnt_d   = '0;
               par_d   = 1'b0;
            end
         end
         DATA: begin
            if (edge_s) begin
               shift_d = {din_s, shift_q[DATA_BITS-1:1]};
               par_d   = par_q ^ din_s;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (edge_s) begin
               par_d   = par_q ^ din_s;
               state_d = STOP;
            end
         end
         STOP: begin
            if (edge_s) begin
               state_d = IDLE;
               // Parity failure outranks a bad stop bit.
               if ((PARITY_EN != 0) && !par_q) begin
                  err_d  = 1'b1;
                  code_d = 2'b01;
               end else if (!din_s) begin
                  err_d  = 1'b1;
                  code_d = 2'b10;
               end else begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A real edge in the terminal-count cycle keeps the frame alive.
      if (state_q != IDLE && !edge_s && to_q == TO_LAST) begin
         state_d = IDLE;
         valid_d = 1'b0;
         err_d   = 1'b1;
         code_d  = 2'b11;
      end
   end

   assign bus.rx_data       = data_q;
   assign bus.rx_valid      = valid_q;
   assign bus.rx_error      = err_q;
   assign bus.rx_error_code = code_q;
   assign bus.rx_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: an 8-bit parity variant and a 7-bit no-parity variant, both with a 20-cycle timeout.
module tb_ps2_frame_receiver;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ps2_frame_receiver_if #(.DATA_BITS(8)) ifa ();
   ps2_frame_receiver_if #(.DATA_BITS(7)) ifb ();

   ps2_frame_receiver #(.DATA_BITS(8), .PARITY_EN(1), .TIMEOUT_CYCLES(20)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   ps2_frame_receiver #(.DATA_BITS(7), .PARITY_EN(0), .TIMEOUT_CYCLES(20)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   int n_cmp = 0;
   int n_err = 0;
   int act_vld [2] = '{0, 0};
   int act_err [2] = '{0, 0};
   int exp_vld [2] = '{0, 0};
   int exp_err [2] = '{0, 0};
   logic [8:0] exp_data [2];
   logic [1:0] exp_code [2];
   bit         en [2];

   always @(negedge clk) begin
      if (ifa.rx_valid === 1'b1) act_vld[0] <= act_vld[0] + 1;
      if (ifa.rx_error === 1'b1) act_err[0] <= act_err[0] + 1;
      if (ifb.rx_valid === 1'b1) act_vld[1] <= act_vld[1] + 1;
      if (ifb.rx_error === 1'b1) act_err[1] <= act_err[1] + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic d, input logic e);
      if (sel == 0) begin
         ifa.ps2_data = d;
         ifa.ps2_clk_posedge = e;
      end else begin
         ifb.ps2_data = d;
         ifb.ps2_clk_posedge = e;
      end
   endtask

   task automatic set_en(input int sel, input bit v);
      en[sel] = v;
      if (sel == 0) ifa.rx_enable = v;
      else          ifb.rx_enable = v;
   endtask

   // Starts and ends on a falling edge; the rising edge in between samples the pulse.
   task automatic pulse(input int sel, input logic d);
      drive(sel, d, 1'b1);
      @(negedge clk);
      drive(sel, d, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sample(input int sel, output logic v, output logic e, output logic [1:0] c,
                         output logic [8:0] d, output logic b);
      if (sel == 0) begin
         v = ifa.rx_valid; e = ifa.rx_error; c = ifa.rx_error_code;
         d = {1'b0, ifa.rx_data}; b = ifa.rx_busy;
      end else begin
         v = ifb.rx_valid; e = ifb.rx_error; c = ifb.rx_error_code;
         d = {2'b00, ifb.rx_data}; b = ifb.rx_busy;
      end
   endtask

   function automatic int nbits(input int sel);
      return (sel == 0) ? 8 : 7;
   endfunction

   function automatic int ones(input logic [8:0] data, input int nb);
      int n = 0;
      for (int i = 0; i < nb; i++) n += int'(data[i]);
      return n;
   endfunction

   function automatic logic good_par(input logic [8:0] data, input int nb);
      return (ones(data, nb) % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   task automatic send_frame(input int sel, input logic [8:0] data, input logic pbit,
                             input logic stopb, input int gapmax, input bit drop_en);
      int nb;
      bit pe;
      bit accept;
      logic [8:0] m;
      logic v, e, b;
      logic [1:0] c;
      logic [8:0] d;
      nb = nbits(sel);
      pe = (sel == 0);
      accept = en[sel];
      m = 9'((10'd1 << nb) - 10'd1);
      pulse(sel, 1'b0);
      idle($urandom_range(0, gapmax));
      if (drop_en) set_en(sel, 1'b0);
      for (int i = 0; i < nb; i++) begin
         pulse(sel, data[i]);
         idle($urandom_range(0, gapmax));
      end
      if (pe) begin
         pulse(sel, pbit);
         idle($urandom_range(0, gapmax));
      end
      pulse(sel, stopb);
      sample(sel, v, e, c, d, b);
      if (!accept) begin
         chk("ignored_vld", {31'd0, v}, 32'd0);
         chk("ignored_err", {31'd0, e}, 32'd0);
      end else if (pe && ((ones(data, nb) + int'(pbit)) % 2 == 0)) begin
         exp_code[sel] = 2'b01;
         exp_err[sel]++;
         chk("par_vld", {31'd0, v}, 32'd0);
         chk("par_err", {31'd0, e}, 32'd1);
      end else if (!stopb) begin
         exp_code[sel] = 2'b10;
         exp_err[sel]++;
         chk("stop_vld", {31'd0, v}, 32'd0);
         chk("stop_err", {31'd0, e}, 32'd1);
      end else begin
         exp_data[sel] = data & m;
         exp_vld[sel]++;
         chk("good_vld", {31'd0, v}, 32'd1);
         chk("good_err", {31'd0, e}, 32'd0);
      end
      chk("frame_code", {30'd0, c}, {30'd0, exp_code[sel]});
      chk("frame_data", {23'd0, d}, {23'd0, exp_data[sel]});
      chk("frame_busy", {31'd0, b}, 32'd0);
   endtask

   initial begin
      logic v, e, b;
      logic [1:0] c;
      logic [8:0] d;
      logic [8:0] rd;
      logic pb;
      int first;
      int r;
      logic [1:0] tcode;
      logic [8:0] tdata;

      rst = 1'b1;
      drive(0, 1'b1, 1'b0);
      drive(1, 1'b1, 1'b0);
      set_en(0, 1'b1);
      set_en(1, 1'b1);
      exp_data[0] = '0; exp_data[1] = '0;
      exp_code[0] = '0; exp_code[1] = '0;
      idle(3);
      for (int s = 0; s < 2; s++) begin
         sample(s, v, e, c, d, b);
         chk("rst_vld",  {31'd0, v}, 32'd0);
         chk("rst_err",  {31'd0, e}, 32'd0);
         chk("rst_code", {30'd0, c}, 32'd0);
         chk("rst_data", {23'd0, d}, 32'd0);
         chk("rst_busy", {31'd0, b}, 32'd0);
      end
      rst = 1'b0;
      idle(2);

      send_frame(0, 9'h01C, 1'b0, 1'b1, 1, 1'b0);
      chk("tp_good_1c", {24'd0, ifa.rx_data}, 32'h1C);
      idle(2);
      send_frame(0, 9'h01C, 1'b1, 1'b1, 1, 1'b0);
      chk("tp_par_code", {30'd0, ifa.rx_error_code}, 32'd1);
      idle(1);
      send_frame(0, 9'h0F0, 1'b1, 1'b0, 1, 1'b0);
      send_frame(0, 9'h0F0, 1'b1, 1'b1, 0, 1'b0);
      chk("tp_f0_data", {24'd0, ifa.rx_data}, 32'hF0);
      chk("tp_f0_code", {30'd0, ifa.rx_error_code}, 32'd2);

      // Timeout: start plus three data edges, then silence.
      pulse(0, 1'b0);
      for (int i = 0; i < 3; i++) pulse(0, 1'($urandom_range(0, 1)));
      first = 0;
      tcode = 2'b00;
      tdata = '0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (first == 0 && ifa.rx_error === 1'b1) begin
            first = k;
            tcode = ifa.rx_error_code;
            tdata = {1'b0, ifa.rx_data};
         end
      end
      exp_code[0] = 2'b11;
      exp_err[0]++;
      chk("to_latency", first, 32'd20);
      chk("to_code", {30'd0, tcode}, 32'd3);
      chk("to_data", {23'd0, tdata}, {23'd0, exp_data[0]});
      chk("to_busy", {31'd0, ifa.rx_busy}, 32'd0);
      send_frame(0, 9'h01C, 1'b0, 1'b1, 2, 1'b0);

      for (int i = 0; i < 3; i++) begin
         pulse(0, 1'b1);
         chk("noise_busy", {31'd0, ifa.rx_busy}, 32'd0);
      end

      set_en(0, 1'b0);
      send_frame(0, 9'h03A, good_par(9'h03A, 8), 1'b1, 1, 1'b0);
      set_en(0, 1'b1);
      send_frame(0, 9'h05B, good_par(9'h05B, 8), 1'b1, 1, 1'b1);
      set_en(0, 1'b1);
      idle(1);

      // Reset during DATA clears outputs on both instances.
      pulse(0, 1'b0);
      pulse(0, 1'b1);
      pulse(0, 1'b0);
      chk("mid_busy_pre", {31'd0, ifa.rx_busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_data[0] = '0; exp_data[1] = '0;
      exp_code[0] = '0; exp_code[1] = '0;
      chk("mid_busy", {31'd0, ifa.rx_busy}, 32'd0);
      chk("mid_vld", {31'd0, ifa.rx_valid}, 32'd0);
      chk("mid_err", {31'd0, ifa.rx_error}, 32'd0);
      chk("mid_data", {24'd0, ifa.rx_data}, 32'd0);
      @(negedge clk);
      chk("mid_vld2", {31'd0, ifa.rx_valid}, 32'd0);
      chk("mid_err2", {31'd0, ifa.rx_error}, 32'd0);

      send_frame(1, 9'h055, 1'b0, 1'b1, 1, 1'b0);
      chk("b_55", {25'd0, ifb.rx_data}, 32'h55);

      for (int i = 0; i < 30; i++) begin
         for (int s = 0; s < 2; s++) begin
            if ($urandom_range(0, 3) == 0) pulse(s, 1'b1);
            rd = 9'($urandom);
            r  = $urandom_range(0, 9);
            pb = good_par(rd, nbits(s));
            if (r == 0) pb = ~pb;
            send_frame(s, rd, pb, (r == 1) ? 1'b0 : 1'b1, 2, 1'b0);
            idle($urandom_range(0, 2));
         end
      end

      idle(2);
      for (int s = 0; s < 2; s++) begin
         chk("cnt_vld", act_vld[s], exp_vld[s]);
         chk("cnt_err", act_err[s], exp_err[s]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
